// File: rtl/sram_port_pkg.sv
// Shared types and constants for the SRAM request/response front-end.
package sram_port_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int RSP_DEPTH  = 2;
    localparam int CREDIT_MAX = 2;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry in-order response buffer holding read data until the consumer takes it.
module sram_rsp_fifo
    import sram_port_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_r [RSP_DEPTH];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;
    logic                  push_en_s;
    logic                  pop_en_s;

    // Upstream credit accounting keeps these guards from ever firing in normal use.
    assign push_en_s = push & (count_r != 2'(RSP_DEPTH));
    assign pop_en_s  = pop & (count_r != 2'd0);

    // Storage, pointers and occupancy; storage is cleared so rdata reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_en_s) begin
                mem_r[wr_ptr_r] <= push_data;
            end
            wr_ptr_r <= wr_ptr_r ^ push_en_s;
            rd_ptr_r <= rd_ptr_r ^ pop_en_s;
            count_r  <= count_r + 2'(push_en_s) - 2'(pop_en_s);
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/sram_req_port.sv
// Valid/ready front-end for a single-port SRAM macro: zero-fill after reset, then
// forward requests and buffer read data with credit-based flow control.
module sram_req_port
    import sram_port_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int WMASK_WIDTH    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   busy,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] clr_cnt_r;
    logic                  inflight_r;
    logic [1:0]            fifo_count_s;
    logic                  pop_s;
    logic                  credit_ok_s;
    logic                  rd_accept_s;

    assign rsp_valid = (fifo_count_s != 2'd0);
    assign pop_s     = rsp_valid & rsp_ready;

    // A pop at the coming edge frees a slot, which is what sustains one read per cycle.
    assign credit_ok_s = (3'(inflight_r) + 3'(fifo_count_s)) < (3'(CREDIT_MAX) + 3'(pop_s));
    assign rd_accept_s = (state_r == RUN) & credit_ok_s & req_valid & ~req_we;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Clear-sweep address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_r <= '0;
        end else if (state_r == CLEAR) begin
            clr_cnt_r <= clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Marks the macro read whose dout must be captured at the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_accept_s;
        end
    end

    // Next state and macro pin drive.
    always_comb begin
        state_nxt_s = state_r;
        req_ready   = 1'b0;
        busy        = 1'b0;
        sram_we     = 1'b0;
        sram_wmask  = req_wmask;
        sram_addr   = req_addr;
        sram_din    = req_wdata;
        case (state_r)
            CLEAR: begin
                busy       = 1'b1;
                sram_we    = 1'b1;
                sram_wmask = '1;
                sram_addr  = clr_cnt_r;
                sram_din   = '0;
                if (clr_cnt_r == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            RUN: begin
                req_ready   = credit_ok_s;
                sram_we     = req_valid & credit_ok_s & req_we;
                state_nxt_s = RUN;
            end
            default: begin
                state_nxt_s = RESET_STATE;
            end
        endcase
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (sram_dout),
        .pop       (pop_s),
        .rdata     (rsp_rdata),
        .count     (fifo_count_s)
    );

endmodule

// File: tb/tb_sram_req_port.sv
// Directed bench for sram_req_port with a behavioural 4096x8 macro model.
module tb_sram_req_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [0:0]  req_wmask;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        sram_we;
    logic [0:0]  sram_wmask;
    logic [11:0] sram_addr;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout;

    logic [7:0]  mem [0:4095];
    logic        fill_en;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_req_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_wmask  (req_wmask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    // Macro model: synchronous read, masked write, dout undefined after a write.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 4096; i++) begin
                mem[i] <= 8'hEE;
            end
        end else if (sram_we) begin
            if (sram_wmask[0]) begin
                mem[sram_addr] <= sram_din;
            end
            sram_dout <= 'x;
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic we, input logic [11:0] a, input logic [7:0] d,
                         input logic m, input string tag);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        #1 chk(tag, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        #1;
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, 32'(rsp_rdata), 32'(exp));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int bad;
        int nrsp;
        int first;
        int last;
        int acc;
        int got;

        fill_en   = 1'b1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wmask = 1'b1;
        req_addr  = 12'h000;
        req_wdata = 8'h00;
        rsp_ready = 1'b0;

        @(negedge clk);
        fill_en = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_sram_we", 32'(sram_we), 32'd1);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_din", 32'(sram_din), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);

        // Clear sweep: address ramps 0..4095 with busy and we high throughout.
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            #1;
            if (!(busy === 1'b1 && sram_we === 1'b1 && sram_wmask === 1'b1 &&
                  sram_din === 8'h00 && sram_addr === 12'(i))) begin
                bad++;
            end
            @(negedge clk);
        end
        chk("clear_ramp_bad_cycles", 32'(bad), 32'd0);
        #1;
        chk("run_busy", 32'(busy), 32'd0);
        chk("run_req_ready", 32'(req_ready), 32'd1);
        chk("run_sram_we_idle", 32'(sram_we), 32'd0);

        // Read of a cleared location, with one-edge capture latency.
        issue(1'b0, 12'h7FF, 8'h00, 1'b1, "rd7ff_accept");
        #1 chk("rd7ff_latency_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        pop_check("rd7ff", 8'h00);

        // Write then back-to-back read of the same address.
        issue(1'b1, 12'h123, 8'hA5, 1'b1, "wr123_accept");
        issue(1'b0, 12'h123, 8'h00, 1'b1, "rd123_accept");
        @(negedge clk);
        pop_check("rd123", 8'hA5);

        // Masked-off write leaves the old contents.
        issue(1'b1, 12'h010, 8'h3C, 1'b1, "wr010_accept");
        issue(1'b1, 12'h010, 8'hFF, 1'b0, "wr010_masked_accept");
        issue(1'b0, 12'h010, 8'h00, 1'b1, "rd010_accept");
        @(negedge clk);
        pop_check("rd010", 8'h3C);

        // Streaming reads with the consumer always ready.
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 12'(i), 8'(8'h40 + i), 1'b1, "fill_accept");
        end
        rsp_ready = 1'b1;
        nrsp  = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 22; c++) begin
            if (rsp_valid === 1'b1) begin
                chk("stream_data", 32'(rsp_rdata), 32'(8'h40 + nrsp));
                if (first < 0) first = c;
                last = c;
                nrsp++;
            end
            if (c < 16) begin
                req_valid = 1'b1;
                req_addr  = 12'(c);
                #1 chk("stream_ready", 32'(req_ready), 32'd1);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("stream_count", 32'(nrsp), 32'd16);
        chk("stream_span", 32'(last - first), 32'd15);

        // Backpressure: only two reads may be outstanding.
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_addr  = 12'(acc);
            #1;
            if (req_ready === 1'b1) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        #1;
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid === 1'b1) begin
                chk("bp_drain_data", 32'(rsp_rdata), 32'(8'h40 + got));
                got++;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("bp_drain_count", 32'(got), 32'd2);
        #1 chk("bp_empty_after", 32'(rsp_valid), 32'd0);
        @(negedge clk);

        // Reset with one read in flight and one entry buffered.
        issue(1'b0, 12'h005, 8'h00, 1'b1, "mid_rd0_accept");
        issue(1'b0, 12'h006, 8'h00, 1'b1, "mid_rd1_accept");
        #1 chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_addr", 32'(sram_addr), 32'd0);
        chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk("restart_addr", 32'(sram_addr), 32'(i));
            @(negedge clk);
        end
        #1 chk("restart_busy", 32'(busy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
